// File: rtl/seq_lighting_pkg.sv
// ----------------------------------------------------------------------------
// seq_lighting_pkg
//   Shared types and constants for the sequential lighting scheduler:
//   pattern mode codes, the scheduler state enum and the per-mode step count.
//   No ports; imported by seq_tick_gen and seq_lighting_ctrl.
// ----------------------------------------------------------------------------
package seq_lighting_pkg;

   typedef enum logic [1:0] {
      MODE_CHASE_FWD = 2'd0,
      MODE_CHASE_REV = 2'd1,
      MODE_PING_PONG = 2'd2,
      MODE_BLINK     = 2'd3
   } mode_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int unsigned BLINK_STEPS = 2;

   // Steps per pass. Ping-pong visits the endpoints once, so it is 2N-2.
   function automatic int unsigned num_steps(input mode_t mode, input int unsigned n_led);
      int unsigned n;
      case (mode)
         MODE_CHASE_FWD: n = n_led;
         MODE_CHASE_REV: n = n_led;
         MODE_PING_PONG: n = 2 * n_led - 2;
         default:        n = BLINK_STEPS;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// ----------------------------------------------------------------------------
// seq_tick_gen
//   Step prescaler. Counts 0..period-1 while enabled and emits a one-cycle
//   tick in the cycle where the count equals period-1; the count then wraps.
// Ports:
//   i_clk     in  1      clock
//   i_reset   in  1      synchronous active-high reset
//   i_clear   in  1      hold the count at zero
//   i_en      in  1      advance the count
//   i_period  in  DIV_W  cycles per tick (>= 2)
//   o_tick    out 1      tick, combinational from the count register
// ----------------------------------------------------------------------------
module seq_tick_gen #(
   parameter int DIV_W = 24
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_en,
   input  logic [DIV_W-1:0] i_period,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_count;
   logic             w_tick;

   assign w_tick = i_en && !i_clear && (r_count == i_period - 1'b1);
   assign o_tick = w_tick;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_count <= '0;
      end else if (i_en) begin
         if (w_tick) r_count <= '0;
         else        r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/seq_lighting_ctrl.sv
// ----------------------------------------------------------------------------
// seq_lighting_ctrl
//   Command-driven scheduler for an N_LED lamp chain. One command (mode,
//   speed, repeat count) is accepted in IDLE, the lamps are stepped at the
//   prescaled rate, and the block returns to IDLE with a one-cycle done pulse
//   after the last pass (or silently on abort).
//
//   Handshake: a command transfers on a rising clock edge where
//   i_cmd_valid && o_cmd_ready. o_cmd_ready is 1 exactly while IDLE; while
//   RUN all command inputs are ignored and i_cmd_valid may stay high.
//
// Ports:
//   i_clk        in  1      clock, posedge
//   i_reset      in  1      synchronous active-high reset
//   i_cmd_valid  in  1      command offered
//   o_cmd_ready  out 1      1 iff IDLE
//   i_cmd_mode   in  2      0 chase fwd, 1 chase rev, 2 ping-pong, 3 blink
//   i_cmd_speed  in  2      step period = TICK_DIV << speed
//   i_cmd_reps   in  REP_W  passes to run, 0 = until abort
//   i_abort      in  1      stop a running pattern (ignored in IDLE)
//   o_led        out N_LED  registered lamp drive, o_led[N_LED-1] is lamp "a"
//   o_busy       out 1      1 iff RUN
//   o_done       out 1      one-cycle pulse on normal completion
//   o_state      out 1      current scheduler state, for observation
// ----------------------------------------------------------------------------
module seq_lighting_ctrl
   import seq_lighting_pkg::*;
#(
   parameter int N_LED    = 5,
   parameter int TICK_DIV = 1000000,
   parameter int DIV_W    = 24,
   parameter int REP_W    = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [1:0]       i_cmd_mode,
   input  logic [1:0]       i_cmd_speed,
   input  logic [REP_W-1:0] i_cmd_reps,
   input  logic             i_abort,
   output logic [N_LED-1:0] o_led,
   output logic             o_busy,
   output logic             o_done,
   output state_t           o_state
);

   localparam int STEP_W = $clog2(2 * N_LED);

   state_t            r_state;
   mode_t             r_mode;
   logic [1:0]        r_speed;
   logic [REP_W-1:0]  r_reps;
   logic [REP_W-1:0]  r_pass;
   logic [STEP_W-1:0] r_step;
   logic [N_LED-1:0]  r_led;
   logic              r_done;

   state_t            w_state_nxt;
   mode_t             w_mode_nxt;
   logic [1:0]        w_speed_nxt;
   logic [REP_W-1:0]  w_reps_nxt;
   logic [REP_W-1:0]  w_pass_nxt;
   logic [STEP_W-1:0] w_step_nxt;
   logic [N_LED-1:0]  w_led_nxt;
   logic              w_done_nxt;

   logic              w_accept;
   logic              w_tick;
   logic [DIV_W-1:0]  w_period;
   logic [STEP_W-1:0] w_last_step;
   logic [REP_W-1:0]  w_pass_inc;

   // Lamp pattern for a given step of a given mode.
   function automatic logic [N_LED-1:0] f_decode(input mode_t mode, input logic [STEP_W-1:0] step);
      logic [N_LED-1:0] pat;
      int               idx;
      int               tgt;
      idx = int'(step);
      case (mode)
         MODE_CHASE_FWD: tgt = N_LED - 1 - idx;
         MODE_CHASE_REV: tgt = idx;
         MODE_PING_PONG: tgt = (idx <= N_LED - 1) ? (N_LED - 1 - idx) : (idx - (N_LED - 1));
         default:        tgt = -1;
      endcase
      for (int i = 0; i < N_LED; i++) pat[i] = (i == tgt);
      if (mode == MODE_BLINK) pat = (step == '0) ? '1 : '0;
      return pat;
   endfunction

   assign w_accept    = (r_state == ST_IDLE) && i_cmd_valid;
   assign w_period    = DIV_W'(TICK_DIV) << r_speed;
   assign w_last_step = STEP_W'(num_steps(r_mode, N_LED) - 1);
   // Saturates so an endless (reps==0) run never wraps back to a match.
   assign w_pass_inc  = (r_pass == '1) ? r_pass : r_pass + 1'b1;

   // Prescaler is held at zero outside RUN, so the first step of a new
   // command always lasts a full period.
   seq_tick_gen #(
      .DIV_W(DIV_W)
   ) u_tick (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clear  (r_state != ST_RUN),
      .i_en     (r_state == ST_RUN),
      .i_period (w_period),
      .o_tick   (w_tick)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_mode  <= MODE_CHASE_FWD;
         r_speed <= '0;
         r_reps  <= '0;
         r_pass  <= '0;
         r_step  <= '0;
         r_led   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_mode  <= w_mode_nxt;
         r_speed <= w_speed_nxt;
         r_reps  <= w_reps_nxt;
         r_pass  <= w_pass_nxt;
         r_step  <= w_step_nxt;
         r_led   <= w_led_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_speed_nxt = r_speed;
      w_reps_nxt  = r_reps;
      w_pass_nxt  = r_pass;
      w_step_nxt  = r_step;
      w_led_nxt   = r_led;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Abort is ignored in IDLE, including when it arrives with a command.
            if (w_accept) begin
               w_state_nxt = ST_RUN;
               w_mode_nxt  = mode_t'(i_cmd_mode);
               w_speed_nxt = i_cmd_speed;
               w_reps_nxt  = i_cmd_reps;
               w_pass_nxt  = '0;
               w_step_nxt  = '0;
               w_led_nxt   = f_decode(mode_t'(i_cmd_mode), '0);
            end
         end
         ST_RUN: begin
            if (i_abort) begin
               // Takes priority over a coinciding final tick: no done pulse.
               w_state_nxt = ST_IDLE;
               w_pass_nxt  = '0;
               w_step_nxt  = '0;
               w_led_nxt   = '0;
            end else if (w_tick) begin
               if (r_step == w_last_step) begin
                  w_step_nxt = '0;
                  w_pass_nxt = w_pass_inc;
                  if ((r_reps != '0) && (w_pass_inc == r_reps)) begin
                     w_state_nxt = ST_IDLE;
                     w_pass_nxt  = '0;
                     w_led_nxt   = '0;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_led_nxt = f_decode(r_mode, '0);
                  end
               end else begin
                  w_step_nxt = r_step + 1'b1;
                  w_led_nxt  = f_decode(r_mode, r_step + 1'b1);
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_led_nxt   = '0;
         end
      endcase
   end

   assign o_cmd_ready = (r_state == ST_IDLE);
   assign o_busy      = (r_state == ST_RUN);
   assign o_led       = r_led;
   assign o_done      = r_done;
   assign o_state     = r_state;

endmodule
